// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_sync and its stream reader: default word width,
// the output buffer depth and the occupancy type used to count buffered words.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry ordered buffer: push writes the tail, pop removes the head, and a
// simultaneous push/pop keeps occupancy constant while preserving order.
module stream_skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output occ_t                  o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    occ_t                  r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    // NOTE: the two data entries are reset along with occupancy so the head
    // reads as zero out of reset; with only two words this costs nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_head take the old r_tail
            // in the same edge that r_tail takes new data.
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_push_data;
                    else               r_tail <= i_push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains fifo_sync into a valid/ready stream, keeping at most one read in
// flight and two words buffered so the sink sees one word per clock.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle
);

    occ_t                 w_occ;
    occ_t                 w_slots;
    logic                 w_pop;
    logic                 w_issue;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_words_out;

    assign w_pop   = m_valid & m_ready;
    assign w_slots = w_occ + {1'b0, r_inflight};

    // NOTE: always_comb assigns its default first so no path leaves w_issue
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_issue = 1'b0;
        if (rst_n && enable && !fifo_empty) begin
            w_issue = (w_slots < occ_t'(BUF_DEPTH)) ||
                      ((w_slots == occ_t'(BUF_DEPTH)) && w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_words_out <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_pop) r_words_out <= r_words_out + 1'b1;
        end
    end

    // The word read last cycle is on fifo_data now and lands in the tail.
    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (m_data)
    );

    assign fifo_rd_en = w_issue;
    assign fifo_cs    = w_issue;
    assign m_valid    = (w_occ != 2'd0);
    assign words_out  = r_words_out;
    assign idle       = (w_occ == 2'd0) && !r_inflight;

endmodule
